// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for the RV32I execute-stage ALU: decodes one
// instruction at a time, holds ALU controls through the ALU latency, and reports a tagged result.
module alu_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic [2:0]       o_ALUop,
  output logic [2:0]       o_func3,
  output logic             o_func7,
  output logic             o_busy,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [TAG_W-1:0] o_res_tag,
  output logic             o_res_branch,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [2:0]       func3_q, func3_d;
  logic             func7_q, func7_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             branch_q, branch_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             dec_legal;
  logic [2:0]       dec_op;
  logic [2:0]       dec_f3;
  logic             dec_f7;
  logic             accept;
  logic             unused_instr;

  assign unused_instr = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = 3'd0;
    dec_f3    = 3'd0;
    dec_f7    = 1'b0;
    unique case (i_instr[6:0])
      7'b0000011, 7'b0100011: dec_op = 3'd0;
      7'b1100011:             dec_op = 3'd1;
      7'b0110011:             dec_op = 3'd2;
      7'b0010011:             dec_op = 3'd3;
      7'b0110111:             dec_op = 3'd4;
      7'b0010111:             dec_op = 3'd5;
      7'b1101111:             dec_op = 3'd6;
      7'b1100111:             dec_op = 3'd7;
      default:                dec_legal = 1'b0;
    endcase
    if (dec_op == 3'd1 || dec_op == 3'd2 || dec_op == 3'd3)
      dec_f3 = i_instr[14:12];
    // instr[30] only selects SUB/SRA/SRAI; ADDI and other I-types must never subtract
    if (dec_op == 3'd2 && (dec_f3 == 3'd0 || dec_f3 == 3'd5))
      dec_f7 = i_instr[30];
    else if (dec_op == 3'd3 && dec_f3 == 3'd5)
      dec_f7 = i_instr[30];
  end

  always_comb begin
    state_d   = state_q;
    alu_op_d  = alu_op_q;
    func3_d   = func3_q;
    func7_d   = func7_q;
    tag_d     = tag_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    o_ready   = !i_flush && ((state_q == IDLE) || (state_q == DONE && i_res_ready));
    accept    = i_valid && o_ready;

    if (i_flush) begin
      state_d   = IDLE;
      illegal_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        EXEC: state_d = DONE;
        DONE: begin
          if (i_res_ready) begin
            cnt_d     = cnt_q + CNT_W'(1);
            state_d   = IDLE;
            illegal_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
      // An accept (from IDLE or a consumed DONE) overrides the default transition
      if (accept) begin
        tag_d = i_tag;
        if (dec_legal) begin
          alu_op_d  = dec_op;
          func3_d   = dec_f3;
          func7_d   = dec_f7;
          branch_d  = (dec_op == 3'd1);
          illegal_d = 1'b0;
          state_d   = EXEC;
        end else begin
          branch_d  = 1'b0;
          illegal_d = 1'b1;
          state_d   = DONE;
        end
      end
    end

    o_ALUop      = alu_op_q;
    o_func3      = func3_q;
    o_func7      = func7_q;
    o_busy       = (state_q != IDLE);
    o_res_valid  = (state_q == DONE);
    o_res_tag    = tag_q;
    o_res_branch = branch_q;
    o_illegal    = illegal_q;
    o_done_cnt   = cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      alu_op_q  <= '0;
      func3_q   <= '0;
      func7_q   <= 1'b0;
      tag_q     <= '0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      alu_op_q  <= alu_op_d;
      func3_q   <= func3_d;
      func7_q   <= func7_d;
      tag_q     <= tag_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing controller in front of the RV32I execute-stage ALU.
- Accepts one instruction at a time over a valid/ready handshake and decodes opcode, func3 and instr[30] into the ALU's 3-bit op-class, func3 and 1-bit func7 controls.
- Holds those controls stable across the ALU's one-cycle registered latency, then presents a tagged result-valid strobe to writeback/branch logic with backpressure, flush and illegal-opcode reporting.

Parameters:
TAG_W  4  width of the instruction tag carried from issue to result
CNT_W  16  width of the completed-operation counter

Ports:
i_clk  input  1  clock; all state on rising edge
i_reset  input  1  asynchronous, active-low reset
i_valid  input  1  upstream presents an instruction
o_ready  output  1  controller accepts instruction this cycle
i_instr  input  32  instruction word; only [6:0], [14:12], [30] decoded
i_tag  input  TAG_W  tag returned with the result
i_flush  input  1  abort in-flight operation, discard result
o_ALUop  output  3  ALU op-class: 0 ld/st, 1 branch, 2 R, 3 I, 4 LUI, 5 AUIPC, 6 JAL, 7 JALR
o_func3  output  3  func3 to ALU
o_func7  output  1  func7 select bit to ALU
o_busy  output  1  upstream must hold ALU operands/immediate/NPC stable while high
o_res_valid  output  1  ALU output is final for the tagged op
i_res_ready  input  1  downstream consumes result
o_res_tag  output  TAG_W  tag of completed op
o_res_branch  output  1  completed op is a branch; ALU branch flag is meaningful
o_illegal  output  1  completed op had an unsupported opcode
o_done_cnt  output  CNT_W  count of results consumed (wraps)

Behaviour:
- Reset (i_reset low, async): state IDLE; o_ALUop=0, o_func3=0, o_func7=0, o_busy=0, o_res_valid=0, o_res_tag=0, o_res_branch=0, o_illegal=0, o_done_cnt=0. Reset mid-operation drops the op silently.
- States: IDLE, EXEC, DONE.
- o_ready = (IDLE) or (DONE and i_res_ready), and only when i_flush is low.
- Accept: i_valid and o_ready at an edge. The decode registers o_ALUop/o_func3/o_func7 and captures i_tag.
- Decode by opcode:
  - 0000011 / 0100011 -> op 0
  - 1100011 -> op 1
  - 0110011 -> op 2
  - 0010011 -> op 3
  - 0110111 -> op 4
  - 0010111 -> op 5
  - 1101111 -> op 6
  - 1100111 -> op 7
- func7 rules:
  - op 2: func7 = instr[30] only when func3 is 0 or 5, else 0.
  - op 3: func7 = instr[30] only when func3 = 5, else 0 (ADDI never subtracts).
  - All other ops: func7 = 0.
- func3 is passed through for ops 1/2/3 and forced to 0 otherwise.
- Legal accept goes to EXEC; o_busy=1. The ALU samples controls at the next edge, and that edge moves the state to DONE.
- Latency: accept edge E0, ALU result registered at E1, o_res_valid high in the cycle after E1. That is 2 cycles from accept to result-valid.
- Illegal opcode: accepted, o_ALUop keeps its previous value, state goes directly to DONE with o_illegal=1 and o_res_branch=0 (latency 1).
- DONE:
  - o_res_valid=1 and o_busy=1; outputs and ALU controls are held while i_res_ready=0. Because the ALU recomputes every edge, operands must stay stable.
  - On i_res_ready, o_done_cnt increments (wraps at 2^CNT_W).
  - Then: if a new instruction is accepted in the same cycle, go to EXEC (or DONE if illegal); otherwise go to IDLE with o_res_valid=0 and o_busy=0.
- Throughput: one op per 2 cycles when downstream is always ready.
- Flush, highest priority after reset:
  - Any state -> IDLE; o_res_valid, o_busy and o_illegal clear next edge; counter not incremented.
  - A flush coinciding with i_res_ready in DONE discards the result.
  - No accept occurs in a flush cycle.
- o_res_branch = (ALUop==1) registered with the op; only valid while o_res_valid.

Test Plan:
- Reset then ADD (instr 0x002081B3, tag 3), i_res_ready=1 -> controls 2/0/0 one cycle after accept; o_res_valid with tag 3 two cycles after accept; o_done_cnt=1.
- SUB 0x40208133 then SRAI 0x4050D093 then ADDI with instr[30]=1 -> func7 = 1, 1, 0; op 2, 3, 3; func3 0, 5, 0.
- BEQ 0x00208463 with i_res_ready held low 4 cycles -> o_res_valid/o_res_branch/o_busy held 4 cycles, controls stable, o_ready=0; counter increments once on release.
- Back-to-back LW, LUI, JAL with i_res_ready=1 and i_valid=1 -> results every 2 cycles, ops 0, 4, 6, tags in order, o_done_cnt=3.
- Opcode 0x7F (illegal) -> o_res_valid and o_illegal one cycle after accept, ALU controls unchanged.
- i_flush asserted in EXEC and again in DONE with i_res_ready=1 -> IDLE next cycle, no o_res_valid pulse consumed, o_done_cnt unchanged; async reset asserted in EXEC clears all outputs immediately.
